bp_fe_queue_buffer: RTL and testbench

Replayable FIFO between the front end and the back-end checker. It holds PC/instruction queue entries produced by the FE. Entries are issued speculatively to the scheduler and kept until the back end commits them. On a cache or TLB miss the queue rolls back to the oldest uncommitted entry; on a pipeline flush it is cleared.

---
 rtl/bp_fe_queue_buffer.sv | 104 ++++++++++
 tb/tb_bp_fe_queue_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_buffer.sv
// Replayable FE->BE queue: entries issue speculatively and stay until committed; roll rewinds, clr empties.
// Latency 1 cycle enqueue-to-output (0 with BP_FE_QUEUE_BYPASS_EN); ready_o depends only on registered pointers.
module bp_fe_queue_buffer #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_clr_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_deq_i
);

  localparam int idx_w_lp = $clog2(els_p);
  localparam int ptr_w_lp = idx_w_lp + 1;

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]  mem_q [els_p];

  logic full, rd_empty;
  logic clr, roll, enq, issue, deq;
  logic [ptr_w_lp-1:0] occ_w, occ_r;

  // Full compares against the commit pointer: issued-but-uncommitted slots are still owned.
  assign full     = (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0])
                  & (wptr_q[idx_w_lp] != cptr_q[idx_w_lp]);
  assign rd_empty = (rptr_q == wptr_q);

  assign fe_queue_ready_o = ~full;

  assign clr   = fe_queue_clr_i;
  assign roll  = fe_queue_roll_i & ~clr;
  assign enq   = fe_queue_v_i & ~full & ~clr;
  assign issue = fe_queue_yumi_i & ~roll & ~clr;
  assign deq   = fe_queue_deq_i & ~clr;

`ifdef BP_FE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass       = rd_empty & enq & ~roll;
  assign fe_queue_v_o = ~rd_empty | bypass;
  assign fe_queue_o   = bypass ? fe_queue_i : mem_q[rptr_q[idx_w_lp-1:0]];
`else
  assign fe_queue_v_o = ~rd_empty;
  assign fe_queue_o   = mem_q[rptr_q[idx_w_lp-1:0]];
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      wptr_d = wptr_q + ptr_w_lp'(enq);
      cptr_d = cptr_q + ptr_w_lp'(deq);
      // Roll lands on the commit pointer after this cycle's retire.
      if (roll) rptr_d = cptr_q + ptr_w_lp'(deq);
      else      rptr_d = rptr_q + ptr_w_lp'(issue);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[idx_w_lp-1:0]] <= fe_queue_i;
  end

  assign occ_w = wptr_q - cptr_q;
  assign occ_r = rptr_q - cptr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (deq)
        assert (cptr_q != rptr_q)
          else $error("bp_fe_queue_buffer: deq with no issued entry");
      if (issue)
        assert (fe_queue_v_o)
          else $error("bp_fe_queue_buffer: yumi without valid entry");
      assert ((occ_r <= occ_w) && (occ_w <= ptr_w_lp'(els_p)))
        else $error("bp_fe_queue_buffer: pointer ordering broken");
    end
  end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer: fill/drain, roll, roll+deq, clr, wrap stress with reset, optional bypass.
module tb_bp_fe_queue_buffer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [127:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [127:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_clr_i;
  logic         fe_queue_roll_i;
  logic         fe_queue_deq_i;

  int vectors = 0;
  int miscompares = 0;

  bp_fe_queue_buffer #(.els_p(8), .width_p(128)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_deq_i   (fe_queue_deq_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    fe_queue_i      = '0;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] hist [0:63];
  int mw, mr, mc, serial;
  logic byp;
  logic [127:0] exp_q;

  initial begin
    idle();
    reset_i = 1'b1;
    tick();
    tick();
    check("reset_v", fe_queue_v_o, 0);
    check("reset_ready", fe_queue_ready_o, 1);
    reset_i = 1'b0;

    // Fill with A0..A7
    for (int i = 0; i < 8; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'hA0 + 128'(i);
      check("fill_ready", fe_queue_ready_o, 1);
`ifndef BP_FE_QUEUE_BYPASS_EN
      if (i == 0) check("no_bypass_v", fe_queue_v_o, 0);
`endif
      tick();
    end
    idle();
    check("full_ready", fe_queue_ready_o, 0);
    check("full_v", fe_queue_v_o, 1);
    check("full_head", fe_queue_o, 128'hA0);

    // Held valid while full changes nothing
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'hEE;
    tick();
    idle();
    check("full_hold_head", fe_queue_o, 128'hA0);
    check("full_hold_ready", fe_queue_ready_o, 0);

    for (int i = 0; i < 8; i++) begin
      fe_queue_yumi_i = 1'b1;
      check("drain_v", fe_queue_v_o, 1);
      check("drain_dat", fe_queue_o, 128'hA0 + 128'(i));
      tick();
    end
    idle();
    check("issued_v", fe_queue_v_o, 0);
    check("issued_ready", fe_queue_ready_o, 0);

    // Deq with a same-cycle enqueue on a full queue: entry must not be admitted
    fe_queue_deq_i = 1'b1;
    fe_queue_v_i   = 1'b1;
    fe_queue_i     = 128'hEE;
    check("deq_full_ready", fe_queue_ready_o, 0);
    tick();
    idle();
    check("deq1_ready", fe_queue_ready_o, 1);
    check("deq1_v", fe_queue_v_o, 0);
    for (int i = 0; i < 7; i++) begin
      fe_queue_deq_i = 1'b1;
      tick();
    end
    idle();
    check("empty_ready", fe_queue_ready_o, 1);
    check("empty_v", fe_queue_v_o, 0);

    // Roll: enqueue B0..B4, issue 4, commit 1, roll with a concurrent enqueue of B5
    for (int i = 0; i < 5; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'hB0 + 128'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      fe_queue_yumi_i = 1'b1;
      check("roll_issue", fe_queue_o, 128'hB0 + 128'(i));
      tick();
    end
    idle();
    fe_queue_deq_i = 1'b1;
    tick();
    idle();
    fe_queue_roll_i = 1'b1;
    fe_queue_v_i    = 1'b1;
    fe_queue_i      = 128'hB5;
    tick();
    idle();
    check("roll_v", fe_queue_v_o, 1);
    check("roll_dat", fe_queue_o, 128'hB1);
    for (int i = 1; i < 6; i++) begin
      fe_queue_yumi_i = 1'b1;
      check("reissue_dat", fe_queue_o, 128'hB0 + 128'(i));
      tick();
    end
    idle();
    check("reissue_end_v", fe_queue_v_o, 0);
    for (int i = 0; i < 5; i++) begin
      fe_queue_deq_i = 1'b1;
      tick();
    end
    idle();

    // Roll + deq + (ignored) yumi with cptr=#0, rptr=#3
    for (int i = 0; i < 4; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'hC0 + 128'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      fe_queue_yumi_i = 1'b1;
      tick();
    end
    idle();
    check("rd_pre_dat", fe_queue_o, 128'hC3);
    fe_queue_roll_i = 1'b1;
    fe_queue_deq_i  = 1'b1;
    fe_queue_yumi_i = 1'b1;
    tick();
    idle();
    check("rolldeq_v", fe_queue_v_o, 1);
    check("rolldeq_dat", fe_queue_o, 128'hC1);
    for (int i = 1; i < 4; i++) begin
      fe_queue_yumi_i = 1'b1;
      check("rolldeq_reissue", fe_queue_o, 128'hC0 + 128'(i));
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      fe_queue_deq_i = 1'b1;
      tick();
    end
    idle();

    // Clr with simultaneous enqueue/yumi/deq on a 6-entry queue
    for (int i = 0; i < 6; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'hD0 + 128'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      fe_queue_yumi_i = 1'b1;
      tick();
    end
    idle();
    fe_queue_clr_i  = 1'b1;
    fe_queue_v_i    = 1'b1;
    fe_queue_i      = 128'hDEAD;
    fe_queue_yumi_i = 1'b1;
    fe_queue_deq_i  = 1'b1;
    tick();
    idle();
    check("clr_v", fe_queue_v_o, 0);
    check("clr_ready", fe_queue_ready_o, 1);
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'hE0;
`ifndef BP_FE_QUEUE_BYPASS_EN
    check("post_clr_enq_v", fe_queue_v_o, 0);
`endif
    tick();
    idle();
    check("post_clr_v", fe_queue_v_o, 1);
    check("post_clr_dat", fe_queue_o, 128'hE0);
    fe_queue_yumi_i = 1'b1;
    tick();
    idle();
    fe_queue_deq_i = 1'b1;
    tick();
    idle();

    // Wrap stress against a pointer model; reset pulsed at cycle 20
    mw = 0; mr = 0; mc = 0; serial = 0;
    for (int i = 0; i < 40; i++) begin
      fe_queue_v_i    = ($urandom_range(0, 7) != 0);
      fe_queue_i      = 128'h1000 + 128'(serial);
      fe_queue_yumi_i = (mr < mw) && ($urandom_range(0, 3) != 0);
      fe_queue_deq_i  = (mc < mr) && ($urandom_range(0, 3) != 0);
      reset_i         = (i == 20);
`ifdef BP_FE_QUEUE_BYPASS_EN
      byp = (mr == mw) && fe_queue_v_i && (mw - mc < 8);
`else
      byp = 1'b0;
`endif
      exp_q = byp ? fe_queue_i : hist[mr % 64];
      check("wrap_ready", fe_queue_ready_o, (mw - mc < 8));
      check("wrap_v", fe_queue_v_o, (mr < mw) || byp);
      if ((mr < mw) || byp) check("wrap_dat", fe_queue_o, exp_q);
      tick();
      if (i == 20) begin
        mw = 0; mr = 0; mc = 0;
        reset_i = 1'b0;
        idle();
        check("wrap_reset_v", fe_queue_v_o, 0);
        check("wrap_reset_ready", fe_queue_ready_o, 1);
      end else begin
        if (fe_queue_v_i && (mw - mc < 8)) begin
          hist[mw % 64] = fe_queue_i;
          mw++;
        end
        if (fe_queue_yumi_i) mr++;
        if (fe_queue_deq_i)  mc++;
      end
      serial++;
    end
    idle();
    reset_i = 1'b0;

`ifdef BP_FE_QUEUE_BYPASS_EN
    fe_queue_clr_i = 1'b1;
    tick();
    idle();
    fe_queue_v_i    = 1'b1;
    fe_queue_i      = 128'h55;
    fe_queue_yumi_i = 1'b1;
    check("bypass_v", fe_queue_v_o, 1);
    check("bypass_dat", fe_queue_o, 128'h55);
    tick();
    idle();
    check("bypass_after_v", fe_queue_v_o, 0);
    fe_queue_roll_i = 1'b1;
    tick();
    idle();
    check("bypass_roll_v", fe_queue_v_o, 1);
    check("bypass_roll_dat", fe_queue_o, 128'h55);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
